// File: rtl/pdm_dac_multi.sv
// ============================================================================
// pdm_dac_multi: multi-channel PCM-to-PDM sigma-delta DAC (1st/2nd order)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_dac_multi #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int ORDER     = 1,
  parameter int SIGNED_IN = 1,
  parameter int DIV       = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] pcm_in,
  input  logic                      pcm_valid,
  output logic                      pcm_ready,
  input  logic                      sample_tick,
  input  logic                      mute,
  input  logic                      underrun_clear,
  output logic                      underrun,
  output logic [7:0]                underrun_count,
  output logic [CHANNELS-1:0]       pdm_out
);

  localparam int               c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] c_MID   = {1'b1, {(WIDTH-1){1'b0}}};

  if ((ORDER != 1) && (ORDER != 2)) begin : g_bad_order
    $error("pdm_dac_multi: ORDER must be 1 or 2");
  end
  if (DIV < 1) begin : g_bad_div
    $error("pdm_dac_multi: DIV must be >= 1");
  end

  logic                      r_pending;
  logic [CHANNELS*WIDTH-1:0] r_frame;
  logic                      r_underrun;
  logic [7:0]                r_underrun_count;
  logic [c_CNT_W-1:0]        r_div_cnt;
  logic                      w_accept;
  logic                      w_underrun_evt;
  logic                      w_strobe;

  assign w_accept       = pcm_valid & ~r_pending;
  assign w_underrun_evt = sample_tick & ~r_pending;
  assign w_strobe       = (r_div_cnt == '0);

  assign pcm_ready      = ~r_pending;
  assign underrun       = r_underrun;
  assign underrun_count = r_underrun_count;

  // Accept only happens while empty, so it always beats a same-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_frame   <= '0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
      r_frame   <= pcm_in;
    end else if (sample_tick) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || underrun_clear) begin
      r_underrun       <= 1'b0;
      r_underrun_count <= 8'd0;
    end else if (w_underrun_evt) begin
      r_underrun <= 1'b1;
      if (r_underrun_count != 8'hFF) begin
        r_underrun_count <= r_underrun_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == c_CNT_W'(DIV - 1)) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [WIDTH-1:0] w_sample;
    logic [WIDTH-1:0] w_conv;
    logic [WIDTH-1:0] r_level;

    assign w_sample = r_frame[ch*WIDTH +: WIDTH];

    if (SIGNED_IN != 0) begin : g_signed
      assign w_conv = {~w_sample[WIDTH-1], w_sample[WIDTH-2:0]};
    end else begin : g_unsigned
      assign w_conv = w_sample;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_level <= c_MID;
      end else if (sample_tick) begin
        if (mute) begin
          r_level <= c_MID;
        end else if (r_pending) begin
          r_level <= w_conv;
        end
      end
    end

    if (ORDER == 1) begin : g_order1
      logic [WIDTH+1:0] r_s;
      logic             w_q;

      assign w_q         = ~r_s[WIDTH+1];
      assign pdm_out[ch] = w_q;

      // {q,q,level} is level - q*2^WIDTH in WIDTH+2 bit two's complement.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_s <= '0;
        end else if (w_strobe) begin
          r_s <= r_s + {w_q, w_q, r_level};
        end
      end
    end else begin : g_order2
      logic signed [WIDTH+3:0] r_s1;
      logic signed [WIDTH+3:0] r_s2;
      logic signed [WIDTH+3:0] w_f;
      logic signed [WIDTH+3:0] w_lvl;
      logic signed [WIDTH+3:0] w_s1_next;
      logic signed [WIDTH+3:0] w_s2_next;
      logic                    w_q;

      assign w_q         = ~r_s2[WIDTH+3];
      assign pdm_out[ch] = w_q;
      assign w_f         = w_q ? {4'b0001, {WIDTH{1'b0}}} : '0;
      assign w_lvl       = {4'b0000, r_level};
      assign w_s1_next   = r_s1 + w_lvl - w_f;
      assign w_s2_next   = r_s2 + w_s1_next - w_f;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_s1 <= '0;
          r_s2 <= '0;
        end else if (w_strobe) begin
          r_s1 <= w_s1_next;
          r_s2 <= w_s2_next;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pdm_dac_multi.sv
// ============================================================================
// tb_pdm_dac_multi: directed self-checking bench for pdm_dac_multi
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdm_dac_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcm_in;
  logic        pcm_valid, pcm_ready, sample_tick, mute, underrun_clear, underrun;
  logic [7:0]  underrun_count;
  logic [1:0]  pdm_out;

  logic [7:0]  b_pcm;
  logic        b_valid, b_ready, b_tick, b_mute, b_clear, b_underrun;
  logic [7:0]  b_count;
  logic [0:0]  b_pdm;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int b_phase = -1;
  int b_bad = 0;
  int b_changes = 0;
  int c0, c1, cb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pdm_dac_multi #(
    .WIDTH(16), .CHANNELS(2), .ORDER(1), .SIGNED_IN(1), .DIV(1)
  ) u_dut (
    .clk(clk), .reset(reset), .pcm_in(pcm_in), .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready), .sample_tick(sample_tick), .mute(mute),
    .underrun_clear(underrun_clear), .underrun(underrun),
    .underrun_count(underrun_count), .pdm_out(pdm_out)
  );

  pdm_dac_multi #(
    .WIDTH(8), .CHANNELS(1), .ORDER(2), .SIGNED_IN(0), .DIV(4)
  ) u_dut_o2 (
    .clk(clk), .reset(reset), .pcm_in(b_pcm), .pcm_valid(b_valid),
    .pcm_ready(b_ready), .sample_tick(b_tick), .mute(b_mute),
    .underrun_clear(b_clear), .underrun(b_underrun),
    .underrun_count(b_count), .pdm_out(b_pdm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_a();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic count_a(input int n, output int ones0, output int ones1);
    ones0 = 0;
    ones1 = 0;
    repeat (n) begin
      step();
      ones0 += int'(pdm_out[0]);
      ones1 += int'(pdm_out[1]);
    end
  endtask

  // Also records the clock phase of every output change of the DIV=4 instance.
  task automatic count_b(input int n, output int ones);
    logic prev;
    ones = 0;
    prev = b_pdm[0];
    repeat (n) begin
      step();
      ones += int'(b_pdm[0]);
      if (b_pdm[0] !== prev) begin
        b_changes++;
        if (b_phase < 0) b_phase = cyc % 4;
        else if ((cyc % 4) != b_phase) b_bad++;
      end
      prev = b_pdm[0];
    end
  endtask

  initial begin
    reset = 1'b1; pcm_in = '0; pcm_valid = 1'b0; sample_tick = 1'b0;
    mute = 1'b0; underrun_clear = 1'b0;
    b_pcm = '0; b_valid = 1'b0; b_tick = 1'b0; b_mute = 1'b0; b_clear = 1'b0;
    step(3);
    check("reset_ready", pcm_ready, 1);
    check("reset_pdm", pdm_out, 2'b11);
    check("reset_underrun", underrun, 0);
    check("reset_count", underrun_count, 0);
    check("reset_o2_pdm", b_pdm, 1);
    reset = 1'b0;

    count_a(4096, c0, c1);
    check("mid_ch0", c0, 2048);
    check("mid_ch1", c1, 2048);
    check("idle_ready", pcm_ready, 1);

    // Signed frame: ch0 C000 -> level 4000, ch1 4000 -> level C000.
    pcm_in = {16'h4000, 16'hC000}; pcm_valid = 1'b1;
    step();
    pcm_valid = 1'b0; pcm_in = $urandom;
    check("ready_drop", pcm_ready, 0);
    step(2);
    check("ready_held", pcm_ready, 0);
    tick_a();
    check("ready_rise", pcm_ready, 1);
    check("tick_no_underrun", underrun, 0);
    count_a(4096, c0, c1);
    check_range("quarter_ch0", c0, 1023, 1025);
    check_range("three_quarter_ch1", c1, 3071, 3073);

    repeat (3) begin tick_a(); step(); end
    check("underrun_flag", underrun, 1);
    check("underrun_cnt3", underrun_count, 3);
    sample_tick = 1'b1; step(300); sample_tick = 1'b0;
    check("underrun_sat", underrun_count, 255);
    underrun_clear = 1'b1; step(); underrun_clear = 1'b0;
    check("clear_flag", underrun, 0);
    check("clear_count", underrun_count, 0);
    tick_a();
    check("count_after_clear", underrun_count, 1);
    sample_tick = 1'b1; underrun_clear = 1'b1; step();
    sample_tick = 1'b0; underrun_clear = 1'b0;
    check("clear_wins_count", underrun_count, 0);
    check("clear_wins_flag", underrun, 0);

    // Accept and tick together: underrun counted, frame held for next tick.
    pcm_in = {16'h8000, 16'h7FFF}; pcm_valid = 1'b1; sample_tick = 1'b1;
    step();
    pcm_valid = 1'b0; sample_tick = 1'b0;
    check("coinc_count", underrun_count, 1);
    check("coinc_held", pcm_ready, 0);
    step(3);
    tick_a();
    check("coinc_apply_count", underrun_count, 1);
    check("coinc_apply_ready", pcm_ready, 1);
    step(4);
    count_a(256, c0, c1);
    check_range("full_ch0", c0, 254, 256);
    check_range("zero_ch1", c1, 0, 1);

    // Mute discards a pending near-full-scale frame.
    pcm_in = {16'h7FFF, 16'h7FFF}; pcm_valid = 1'b1;
    step();
    pcm_valid = 1'b0;
    check("mute_pending", pcm_ready, 0);
    mute = 1'b1; tick_a(); mute = 1'b0;
    check("mute_ready", pcm_ready, 1);
    check("mute_no_underrun", underrun_count, 1);
    count_a(4096, c0, c1);
    check_range("mute_ch0", c0, 2047, 2049);
    check_range("mute_ch1", c1, 2047, 2049);
    tick_a();
    check("mute_discarded", underrun_count, 2);

    // Reset with a frame pending drops it.
    pcm_in = {16'h1234, 16'h5678}; pcm_valid = 1'b1;
    step();
    pcm_valid = 1'b0;
    check("pre_reset_pending", pcm_ready, 0);
    reset = 1'b1; step(); reset = 1'b0;
    check("midreset_ready", pcm_ready, 1);
    check("midreset_count", underrun_count, 0);
    check("midreset_pdm", pdm_out, 2'b11);
    step();
    tick_a();
    check("midreset_dropped", underrun_count, 1);

    // Second-order, DIV=4, 8-bit offset-binary instance.
    b_pcm = 8'd64; b_valid = 1'b1; step(); b_valid = 1'b0;
    b_tick = 1'b1; step(); b_tick = 1'b0;
    step(8);
    count_b(4096, cb);
    check_range("o2_level64", cb, 1000, 1048);
    b_pcm = 8'd224; b_valid = 1'b1; step(); b_valid = 1'b0;
    b_tick = 1'b1; step(); b_tick = 1'b0;
    step(8);
    count_b(4096, cb);
    check_range("o2_level224", cb, 3560, 3608);
    check("o2_change_phase", b_bad, 0);
    check_range("o2_changes", b_changes, 100, 4096);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
